fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// cpu_pkg      : shared CPU constants (instruction width).
// fetch_unit   : instruction fetch stage with a one-cycle fetch latency.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   pc             out  fetch address to program memory (registered)
//   instr_in       in   instruction read combinationally from memory at pc
//   stall          in   downstream not ready; freeze the fetch stage
//   branch_taken   in   relative redirect, target = ir_pc + branch_offset
//   branch_offset  in   signed two's-complement branch offset
//   jump           in   absolute redirect to jump_target
//   jump_target    in   absolute redirect address
//   halt_req       in   stop fetching until the next reset
//   ir             out  registered instruction presented to decode
//   ir_pc          out  address ir was fetched from
//   ir_valid       out  ir holds a live instruction
//   halted         out  stage is in the HALTED state
//
// RUN priority: halt_req > jump > branch_taken > stall > normal advance.
// A redirect squashes the in-flight fetch by dropping ir_valid for one cycle.
// -----------------------------------------------------------------------------
package cpu_pkg;
  localparam int I_WIDTH = 16;
endpackage

module fetch_unit #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = cpu_pkg::I_WIDTH,
  parameter int OFFSET_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ADDR_WIDTH-1:0]   pc,
  input  logic [DATA_WIDTH-1:0]   instr_in,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [OFFSET_WIDTH-1:0] branch_offset,
  input  logic                    jump,
  input  logic [ADDR_WIDTH-1:0]   jump_target,
  input  logic                    halt_req,
  output logic [DATA_WIDTH-1:0]   ir,
  output logic [ADDR_WIDTH-1:0]   ir_pc,
  output logic                    ir_valid,
  output logic                    halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0]   offset_ext;
  logic [ADDR_WIDTH-1:0]   branch_pc;

  assign pc = pc_q;

  // Bring the offset to PC width: sign-extend when narrower, otherwise keep
  // only the low bits, since the target wraps modulo 2^ADDR_WIDTH anyway.
  generate
    if (OFFSET_WIDTH >= ADDR_WIDTH) begin : g_offset_trunc
      assign offset_ext = branch_offset[ADDR_WIDTH-1:0];
    end else begin : g_offset_sext
      assign offset_ext = {{(ADDR_WIDTH-OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}},
                           branch_offset};
    end
  endgenerate

  // Branches are relative to the instruction being decoded (ir_pc), not to
  // the fetch address, which is already one ahead.
  assign branch_pc = ir_pc + offset_ext;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers; the async reset sits in the sensitivity
  // list so outputs clear without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc_q     <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= RUN;
        end

        RUN: begin
          if (halt_req) begin
            state    <= HALTED;
            halted   <= 1'b1;
            ir_valid <= 1'b0;
          end else if (jump) begin
            pc_q     <= jump_target;
            ir_valid <= 1'b0;
          end else if (branch_taken) begin
            pc_q     <= branch_pc;
            ir_valid <= 1'b0;
          end else if (!stall) begin
            ir       <= instr_in;
            ir_pc    <= pc_q;
            ir_valid <= 1'b1;
            pc_q     <= pc_q + ADDR_WIDTH'(1);
          end
        end

        // Terminal until reset; every input is ignored here.
        HALTED: begin
          halted   <= 1'b1;
          ir_valid <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit : directed bench for fetch_unit. Program memory word[k] holds
// k + 0x100 and is read combinationally at pc. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int AW = 6;
  localparam int DW = cpu_pkg::I_WIDTH;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr_in;
  logic          stall;
  logic          branch_taken;
  logic [OW-1:0] branch_offset;
  logic          jump;
  logic [AW-1:0] jump_target;
  logic          halt_req;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          halted;

  logic [DW-1:0] mem [64];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign instr_in = mem[pc];

  fetch_unit #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .OFFSET_WIDTH(OW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .instr_in     (instr_in),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .halt_req     (halt_req),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .halted       (halted)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = '0;
    jump          = 1'b0;
    jump_target   = '0;
    halt_req      = 1'b0;
  endtask

  task automatic jump_to(input logic [AW-1:0] tgt);
    jump        = 1'b1;
    jump_target = tgt;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    jump        = 1'b1;
    jump_target = 6'd33;
    @(negedge clk);
    total++; if (pc !== 6'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", pc); end
    total++; if (ir !== 16'h0) begin bad++; $display("FAIL reset_ir: got %h want 0000", ir); end
    total++; if (ir_pc !== 6'd0) begin bad++; $display("FAIL reset_ir_pc: got %0d want 0", ir_pc); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ir_valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
    clear_inputs();
    reset = 1'b0;
    tick();
    // First edge after release only leaves IDLE.
    total++; if (pc !== 6'd0) begin bad++; $display("FAIL idle_pc: got %0d want 0", pc); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", ir_valid); end
  endtask

  task automatic test_sequence();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (ir !== 16'(16'h100 + k)) begin bad++; $display("FAIL seq_ir[%0d]: got %h want %h", k, ir, 16'(16'h100 + k)); end
      total++; if (ir_pc !== 6'(k)) begin bad++; $display("FAIL seq_ir_pc[%0d]: got %0d want %0d", k, ir_pc, k); end
      total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d]: got %b want 1", k, ir_valid); end
      total++; if (pc !== 6'(k + 1)) begin bad++; $display("FAIL seq_pc[%0d]: got %0d want %0d", k, pc, k + 1); end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_ir_pc;
    logic [AW-1:0] exp_pc;
    jump_to(6'd62);
    total++; if (pc !== 6'd62) begin bad++; $display("FAIL wrap_jump_pc: got %0d want 62", pc); end
    for (int k = 0; k < 4; k++) begin
      exp_ir_pc = 6'((62 + k) % 64);
      exp_pc    = 6'((63 + k) % 64);
      tick();
      total++; if (ir_pc !== exp_ir_pc) begin bad++; $display("FAIL wrap_ir_pc[%0d]: got %0d want %0d", k, ir_pc, exp_ir_pc); end
      total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid[%0d]: got %b want 1", k, ir_valid); end
      total++; if (pc !== exp_pc) begin bad++; $display("FAIL wrap_pc[%0d]: got %0d want %0d", k, pc, exp_pc); end
    end
  endtask

  task automatic test_branch();
    jump_to(6'd10);
    tick();
    total++; if (ir_pc !== 6'd10) begin bad++; $display("FAIL br_setup_ir_pc: got %0d want 10", ir_pc); end
    branch_taken  = 1'b1;
    branch_offset = 6'h3C;  // -4
    tick();
    clear_inputs();
    total++; if (pc !== 6'd6) begin bad++; $display("FAIL br_neg_pc: got %0d want 6", pc); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL br_neg_valid: got %b want 0", ir_valid); end
    total++; if (ir_pc !== 6'd10) begin bad++; $display("FAIL br_neg_ir_pc_hold: got %0d want 10", ir_pc); end
    tick();
    total++; if (ir_pc !== 6'd6) begin bad++; $display("FAIL br_neg_target_ir_pc: got %0d want 6", ir_pc); end
    total++; if (ir !== 16'h106) begin bad++; $display("FAIL br_neg_target_ir: got %h want 0106", ir); end
    total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL br_neg_target_valid: got %b want 1", ir_valid); end

    jump_to(6'd60);
    tick();
    branch_taken  = 1'b1;
    branch_offset = 6'd5;
    tick();
    clear_inputs();
    total++; if (pc !== 6'd1) begin bad++; $display("FAIL br_pos_wrap_pc: got %0d want 1", pc); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL br_pos_valid: got %b want 0", ir_valid); end
    tick();
    total++; if (ir_pc !== 6'd1) begin bad++; $display("FAIL br_pos_target_ir_pc: got %0d want 1", ir_pc); end
    total++; if (ir !== 16'h101) begin bad++; $display("FAIL br_pos_target_ir: got %h want 0101", ir); end
  endtask

  task automatic test_stall();
    jump_to(6'd4);
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (pc !== 6'd5) begin bad++; $display("FAIL stall_pc[%0d]: got %0d want 5", k, pc); end
      total++; if (ir !== 16'h104) begin bad++; $display("FAIL stall_ir[%0d]: got %h want 0104", k, ir); end
      total++; if (ir_pc !== 6'd4) begin bad++; $display("FAIL stall_ir_pc[%0d]: got %0d want 4", k, ir_pc); end
      total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", k, ir_valid); end
    end
    stall = 1'b0;
    tick();
    total++; if (ir_pc !== 6'd5) begin bad++; $display("FAIL stall_release_ir_pc: got %0d want 5", ir_pc); end
    total++; if (ir !== 16'h105) begin bad++; $display("FAIL stall_release_ir: got %h want 0105", ir); end
    total++; if (pc !== 6'd6) begin bad++; $display("FAIL stall_release_pc: got %0d want 6", pc); end
  endtask

  task automatic test_priority();
    // Entry state: pc=6, ir_pc=5.
    jump          = 1'b1;
    jump_target   = 6'd20;
    branch_taken  = 1'b1;
    branch_offset = 6'd3;
    stall         = 1'b1;
    tick();
    clear_inputs();
    total++; if (pc !== 6'd20) begin bad++; $display("FAIL prio_jump_pc: got %0d want 20", pc); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL prio_jump_valid: got %b want 0", ir_valid); end
    total++; if (ir_pc !== 6'd5) begin bad++; $display("FAIL prio_jump_ir_pc_hold: got %0d want 5", ir_pc); end
    tick();
    total++; if (ir_pc !== 6'd20) begin bad++; $display("FAIL prio_target_ir_pc: got %0d want 20", ir_pc); end

    halt_req    = 1'b1;
    jump        = 1'b1;
    jump_target = 6'd40;
    tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag: got %b want 1", halted); end
    total++; if (pc !== 6'd21) begin bad++; $display("FAIL halt_pc: got %0d want 21", pc); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL halt_valid: got %b want 0", ir_valid); end
    total++; if (ir_pc !== 6'd20) begin bad++; $display("FAIL halt_ir_pc: got %0d want 20", ir_pc); end
    halt_req      = 1'b0;
    branch_taken  = 1'b1;
    branch_offset = 6'd7;
    tick();
    tick();
    clear_inputs();
    total++; if (pc !== 6'd21) begin bad++; $display("FAIL halted_frozen_pc: got %0d want 21", pc); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halted_sticky: got %b want 1", halted); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL halted_valid: got %b want 0", ir_valid); end
  endtask

  task automatic test_async_reset();
    // Leave HALTED through reset.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL unhalt_flag: got %b want 0", halted); end
    jump_to(6'd29);
    tick();
    total++; if (pc !== 6'd30) begin bad++; $display("FAIL ar_setup_pc: got %0d want 30", pc); end
    total++; if (ir !== 16'h11D) begin bad++; $display("FAIL ar_setup_ir: got %h want 011d", ir); end
    // Pulse reset between edges with a stall pending.
    stall = 1'b1;
    #1 reset = 1'b1;
    #1;
    total++; if (pc !== 6'd0) begin bad++; $display("FAIL ar_pc: got %0d want 0", pc); end
    total++; if (ir !== 16'h0) begin bad++; $display("FAIL ar_ir: got %h want 0000", ir); end
    total++; if (ir_pc !== 6'd0) begin bad++; $display("FAIL ar_ir_pc: got %0d want 0", ir_pc); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", ir_valid); end
    #1 reset = 1'b0;
    clear_inputs();
    tick();
    total++; if (pc !== 6'd0) begin bad++; $display("FAIL ar_idle_pc: got %0d want 0", pc); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL ar_idle_valid: got %b want 0", ir_valid); end
    tick();
    total++; if (ir_pc !== 6'd0) begin bad++; $display("FAIL ar_restart_ir_pc: got %0d want 0", ir_pc); end
    total++; if (ir !== 16'h100) begin bad++; $display("FAIL ar_restart_ir: got %h want 0100", ir); end
    total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL ar_restart_valid: got %b want 1", ir_valid); end
    total++; if (pc !== 6'd1) begin bad++; $display("FAIL ar_restart_pc: got %0d want 1", pc); end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 16'(16'h100 + k);
    test_reset();
    test_sequence();
    test_wrap();
    test_branch();
    test_stall();
    test_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
